// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and default parameters for the DRAM port arbiter.
package dram_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Requester-side and DRAM-master-side buses of the arbiter.
interface dram_req_if #(
  parameter int NUM_REQ = dram_arb_pkg::NUM_REQ,
  parameter int ADDR_W  = dram_arb_pkg::ADDR_W,
  parameter int DATA_W  = dram_arb_pkg::DATA_W
);
  logic [NUM_REQ-1:0]             req_read;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_address;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]              req_readdata;
  logic [NUM_REQ-1:0]             req_dataready;
  logic [NUM_REQ-1:0]             req_writedone;

  // Requesters drive requests; the arbiter answers with completions.
  modport master (
    output req_read, req_write, req_address, req_writedata,
    input  req_readdata, req_dataready, req_writedone
  );
  modport slave (
    input  req_read, req_write, req_address, req_writedata,
    output req_readdata, req_dataready, req_writedone
  );
endinterface

interface dram_mem_if #(
  parameter int ADDR_W = dram_arb_pkg::ADDR_W,
  parameter int DATA_W = dram_arb_pkg::DATA_W
);
  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic              m_dataready;
  logic              m_writedone;

  // The arbiter is the master of this bus; DRAM_master is the slave.
  modport master (
    output m_read, m_write, m_address, m_writedata,
    input  m_readdata, m_dataready, m_writedone
  );
  modport slave (
    input  m_read, m_write, m_address, m_writedata,
    output m_readdata, m_dataready, m_writedone
  );
endinterface

// File: rtl/dram_port_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after rr_ptr_i, wrapping.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    // NOTE: every output and temporary gets a default first so no path leaves
    // a value unassigned; otherwise a latch is inferred.
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(rr_ptr_i) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one DRAM master port among NUM_REQ requesters,
// one transaction at a time, with a sticky watchdog on missing completions.
module dram_port_arbiter #(
  parameter  int NUM_REQ = dram_arb_pkg::NUM_REQ,
  parameter  int ADDR_W  = dram_arb_pkg::ADDR_W,
  parameter  int DATA_W  = dram_arb_pkg::DATA_W,
  parameter  int TIMEOUT = dram_arb_pkg::TIMEOUT,
  localparam int IDX_W   = $clog2(NUM_REQ),
  localparam int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic             clock,
  input  logic             reset,
  dram_req_if.slave        req,
  dram_mem_if.master       mem,
  output logic             busy,
  output logic             timeout_err,
  output logic [IDX_W-1:0] grant_id
);
  import dram_arb_pkg::*;

  state_e            state_q;
  op_e               op_q;
  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [CNT_W-1:0]  wd_cnt_q;
  logic              m_read_q;
  logic              m_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              timeout_q;

  logic [NUM_REQ-1:0] req_vec;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  assign req_vec = req.req_read | req.req_write;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i    (req_vec),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  logic               in_wait;
  logic               rd_done;
  logic               wr_done;
  logic               wd_expire;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]   next_ptr;

  // Completions are forwarded combinationally; reset suppresses them at once.
  assign in_wait   = (state_q == WAIT) && !reset;
  assign rd_done   = in_wait && (op_q == OP_READ)  && mem.m_dataready;
  assign wr_done   = in_wait && (op_q == OP_WRITE) && mem.m_writedone;
  assign wd_expire = in_wait && !rd_done && !wr_done &&
                     (wd_cnt_q == CNT_W'(TIMEOUT - 1));
  assign grant_oh  = NUM_REQ'(1) << grant_q;
  assign next_ptr  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_READ;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      wd_cnt_q  <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q   <= pick_idx;
            op_q      <= req.req_read[pick_idx] ? OP_READ : OP_WRITE;
            m_read_q  <= req.req_read[pick_idx];
            m_write_q <= !req.req_read[pick_idx];
            addr_q    <= req.req_address[pick_idx];
            wdata_q   <= req.req_writedata[pick_idx];
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          m_read_q  <= 1'b0;
          m_write_q <= 1'b0;
          wd_cnt_q  <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (rd_done || wr_done || wd_expire) begin
            rr_ptr_q <= next_ptr;
            state_q  <= IDLE;
            if (wd_expire) timeout_q <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.m_read        = m_read_q;
  assign mem.m_write       = m_write_q;
  assign mem.m_address     = addr_q;
  assign mem.m_writedata   = wdata_q;
  assign req.req_dataready = rd_done ? grant_oh : '0;
  assign req.req_writedone = wr_done ? grant_oh : '0;
  assign req.req_readdata  = rd_done ? mem.m_readdata : '0;
  assign busy              = (state_q != IDLE);
  assign timeout_err       = timeout_q;
  assign grant_id          = grant_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench: queued requester jobs, a round-robin queue model for the
// expected issue order, and a randomized DRAM master responder.
module tb_dram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic         clock;
  logic         reset;
  logic         busy;
  logic         timeout_err;
  logic [1:0]   grant_id;

  dram_req_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) rq ();
  dram_mem_if #(.ADDR_W(AW), .DATA_W(DW)) mm ();

  dram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (rq),
    .mem         (mm),
    .busy        (busy),
    .timeout_err (timeout_err),
    .grant_id    (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { bit is_rd; bit is_wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } job_t;
  typedef struct { int idx; bit rd; logic [AW-1:0] addr; logic [DW-1:0] wdata; } iss_t;
  typedef struct { int idx; bit rd; logic [DW-1:0] data; } done_t;

  job_t  jobs [N][$];
  iss_t  exp_issue [$];
  done_t exp_done [$];

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_ptr  = 0;
  int issue_cnt = 0;
  int wr_done_cnt = 0;
  int rd_done_cnt = 0;

  bit no_resp = 0, junk_en = 0, force_en = 0;
  logic [DW-1:0] force_data = '0;
  bit m_pending = 0, m_rd = 0;
  int m_lat = 0;
  logic [DW-1:0] m_data = '0;
  logic [N-1:0] seen_rd = '0, seen_wr = '0;
  bit prev_strobe = 0, busy_s = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: serve pending jobs round-robin over requesters that still
  // have work, read before write for a job carrying both.
  task automatic build_expected();
    job_t cp [N][$];
    job_t j;
    iss_t e;
    int   found;
    for (int i = 0; i < N; i++) cp[i] = jobs[i];
    forever begin
      found = -1;
      for (int k = 0; k < N; k++)
        if (found < 0 && cp[(mdl_ptr + k) % N].size() > 0) found = (mdl_ptr + k) % N;
      if (found < 0) break;
      j = cp[found][0];
      e.idx = found; e.rd = j.is_rd; e.addr = j.addr; e.wdata = j.wdata;
      exp_issue.push_back(e);
      if (j.is_rd) j.is_rd = 0; else j.is_wr = 0;
      if (!j.is_rd && !j.is_wr) void'(cp[found].pop_front());
      else cp[found][0] = j;
      mdl_ptr = (found + 1) % N;
    end
  endtask

  task automatic load(input int i, input bit rd, input bit wr,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    job_t j;
    j.is_rd = rd; j.is_wr = wr; j.addr = addr; j.wdata = wdata;
    jobs[i].push_back(j);
  endtask

  function automatic bit all_quiet();
    int pend = 0;
    for (int i = 0; i < N; i++) pend += jobs[i].size();
    return (pend == 0) && (exp_issue.size() == 0) && (exp_done.size() == 0) &&
           !m_pending && !busy_s;
  endfunction

  task automatic drain(input int budget);
    bit ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clock);
      if (all_quiet()) ok = 1;
    end
    check("drain_in_budget", ok, 1);
  endtask

  task automatic wait_issue(input int target, input int budget);
    bit ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clock);
      if (issue_cnt >= target) ok = 1;
    end
    check("issue_seen", ok, 1);
  endtask

  task automatic check_reset_state();
    check("rst_m_read", mm.m_read, 0);
    check("rst_m_write", mm.m_write, 0);
    check("rst_m_address", mm.m_address, 0);
    check("rst_m_writedata", mm.m_writedata, 0);
    check("rst_readdata", rq.req_readdata, 0);
    check("rst_dataready", rq.req_dataready, 0);
    check("rst_writedone", rq.req_writedone, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_grant_id", grant_id, 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < N; i++) jobs[i].delete();
    exp_issue.delete();
    exp_done.delete();
    m_pending = 0;
    mdl_ptr   = 0;
    @(posedge clock);
    @(negedge clock);
    check_reset_state();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Monitor: checks each issue strobe and each completion against the queues.
  always @(negedge clock) begin : monitor
    iss_t e;
    done_t d;
    logic [N-1:0] oh;
    if (mm.m_read || mm.m_write) begin
      check("strobe_one_cycle", prev_strobe, 0);
      check("strobe_exclusive", mm.m_read & mm.m_write, 0);
      check("busy_at_issue", busy, 1);
      check("issue_expected", exp_issue.size() > 0, 1);
      if (exp_issue.size() > 0) begin
        e = exp_issue.pop_front();
        check("grant_id", grant_id, e.idx);
        check("issue_is_read", mm.m_read, e.rd);
        check("m_address", mm.m_address, e.addr);
        check("m_writedata", mm.m_writedata, e.wdata);
        if (!no_resp) begin
          d.idx = e.idx; d.rd = e.rd;
          d.data = force_en ? force_data : DW'($urandom);
          exp_done.push_back(d);
          m_pending = 1; m_rd = e.rd; m_lat = $urandom_range(0, 4); m_data = d.data;
        end
      end
      issue_cnt++;
    end
    prev_strobe = mm.m_read | mm.m_write;
    if (|(rq.req_dataready | rq.req_writedone)) begin
      check("done_expected", exp_done.size() > 0, 1);
      if (exp_done.size() > 0) begin
        d  = exp_done.pop_front();
        oh = N'(1) << d.idx;
        check("req_dataready", rq.req_dataready, d.rd ? oh : '0);
        check("req_writedone", rq.req_writedone, d.rd ? '0 : oh);
        check("req_readdata", rq.req_readdata, d.rd ? d.data : '0);
      end
    end
    seen_rd = seen_rd | rq.req_dataready;
    seen_wr = seen_wr | rq.req_writedone;
    rd_done_cnt += $countones(rq.req_dataready);
    wr_done_cnt += $countones(rq.req_writedone);
    busy_s = busy;
  end

  // Master responder and requester drivers, updated just after each edge.
  always @(posedge clock) begin : driver
    job_t j;
    #1;
    mm.m_dataready = 1'b0;
    mm.m_writedone = 1'b0;
    mm.m_readdata  = DW'($urandom);
    if (m_pending) begin
      if (m_lat == 0) begin
        if (m_rd) begin mm.m_dataready = 1'b1; mm.m_readdata = m_data; end
        else mm.m_writedone = 1'b1;
        m_pending = 0;
      end else begin
        m_lat--;
        if (junk_en && $urandom_range(0, 1) == 1) begin
          if (m_rd) mm.m_writedone = 1'b1; else mm.m_dataready = 1'b1;
        end
      end
    end else if (junk_en && $urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) == 1) mm.m_dataready = 1'b1; else mm.m_writedone = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (jobs[i].size() > 0) begin
        j = jobs[i][0];
        if (seen_rd[i]) j.is_rd = 0;
        if (seen_wr[i]) j.is_wr = 0;
        if (!j.is_rd && !j.is_wr) void'(jobs[i].pop_front());
        else jobs[i][0] = j;
      end
      if (jobs[i].size() > 0) begin
        j = jobs[i][0];
        rq.req_read[i]      = j.is_rd;
        rq.req_write[i]     = j.is_wr;
        rq.req_address[i]   = j.addr;
        rq.req_writedata[i] = j.wdata;
      end else begin
        rq.req_read[i]  = 1'b0;
        rq.req_write[i] = 1'b0;
      end
    end
    seen_rd = '0;
    seen_wr = '0;
  end

  initial begin : stimulus
    int base;
    int w;
    int n;
    int t;
    bit te_last;
    reset = 1'b1;
    rq.req_read = '0; rq.req_write = '0; rq.req_address = '0; rq.req_writedata = '0;
    mm.m_readdata = '0; mm.m_dataready = 1'b0; mm.m_writedone = 1'b0;

    do_reset();

    // Simultaneous reads from reset: 0 then 1.
    @(posedge clock);
    load(0, 1, 0, 32'h10, DW'($urandom));
    load(1, 1, 0, 32'h14, DW'($urandom));
    build_expected();
    drain(100);

    // Single read from requester 2 with a fixed return value.
    @(posedge clock);
    force_en = 1; force_data = 32'hDEADBEEF;
    load(2, 1, 0, 32'h100, DW'($urandom));
    build_expected();
    drain(100);
    force_en = 0;

    // Pointer now sits at 3, so 3 beats 0.
    load(3, 1, 0, 32'h30, DW'($urandom));
    load(0, 0, 1, 32'h34, DW'($urandom));
    build_expected();
    drain(100);

    // Fairness: four writers, two writes each.
    do_reset();
    base = wr_done_cnt;
    @(posedge clock);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) load(i, 0, 1, AW'(32'h1000 + 16 * i + r), DW'($urandom));
    build_expected();
    drain(200);
    check("fair_writedone_count", wr_done_cnt - base, 8);

    // Read and write together on requester 3.
    @(posedge clock);
    load(3, 1, 1, 32'h300, DW'($urandom));
    load(0, 0, 1, 32'h304, DW'($urandom));
    build_expected();
    drain(100);

    // Watchdog: master never answers.
    @(posedge clock);
    no_resp = 1;
    load(1, 1, 0, 32'h40, DW'($urandom));
    build_expected();
    wait_issue(issue_cnt + 1, 20);
    jobs[1].delete();
    w = 0; te_last = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (!busy) break;
      w++;
      te_last = timeout_err;
    end
    check("wd_wait_cycles", w, TO);
    check("wd_err_during_wait", te_last, 0);
    check("wd_err_set", timeout_err, 1);

    // Reset in WAIT: abort, then arbitration restarts from pointer 0.
    @(posedge clock);
    load(2, 1, 0, 32'h200, DW'($urandom));
    build_expected();
    wait_issue(issue_cnt + 1, 20);
    jobs[2].delete();
    repeat (3) @(negedge clock);
    check("wd_err_sticky", timeout_err, 1);
    check("busy_in_wait", busy, 1);
    do_reset();
    no_resp = 0;
    @(posedge clock);
    load(1, 1, 0, 32'h50, DW'($urandom));
    load(3, 0, 1, 32'h54, DW'($urandom));
    build_expected();
    drain(100);

    // Randomized traffic with stray and wrong-type completion pulses.
    junk_en = 1;
    for (int round = 0; round < 4; round++) begin
      @(posedge clock);
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          t = $urandom_range(0, 2);
          load(i, t != 1, t != 0, AW'($urandom), DW'($urandom));
        end
      end
      build_expected();
      drain(600);
    end
    junk_en = 0;
    check("final_no_timeout", timeout_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
